decoder_nand_nor: RTL and testbench

//  Universal-gate generator built on a 2-to-4 line decoder: each lane decodes {a,b} to

---
 rtl/decoder_nand_nor_pkg.sv | 12 +
 rtl/decoder_nand_nor_dec2to4.sv | 17 +
 rtl/decoder_nand_nor.sv | 99 +++++++++
 tb/tb_decoder_nand_nor.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/decoder_nand_nor_pkg.sv
// Shared definitions for the decoder-based NAND/NOR generator: minterm indices
// and the one-hot decoder output type.
package decoder_nand_nor_pkg;

    localparam int SEL_00 = 0;
    localparam int SEL_01 = 1;
    localparam int SEL_10 = 2;
    localparam int SEL_11 = 3;

    typedef logic [3:0] dec4_t;

endpackage

// File: rtl/decoder_nand_nor_dec2to4.sv
// 2-to-4 line decoder without enable: exactly one output minterm is high for
// each 2-bit select value.
module dec2to4
    import decoder_nand_nor_pkg::*;
(
    input  logic [1:0] sel_i,
    output dec4_t      y_o
);

    always_comb begin
        y_o = '0;
        for (int k = 0; k < 4; k++) begin
            y_o[k] = (sel_i == 2'(k));
        end
    end

endmodule

// File: rtl/decoder_nand_nor.sv
// Universal-gate generator: per-lane 2-to-4 decode, minterms ORed into NAND/NOR,
// plus a one-stage registered copy. DECODER_NAND_NOR_FULLSET_EN adds AND/OR/XOR/XNOR.
module decoder_nand_nor
    import decoder_nand_nor_pkg::*;
#(
    parameter int WIDTH = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    input  logic               in_valid,
    output logic [WIDTH-1:0]   nand_g,
    output logic [WIDTH-1:0]   nor_g,
    output logic [4*WIDTH-1:0] dec_y,
    output logic [WIDTH-1:0]   nand_q,
    output logic [WIDTH-1:0]   nor_q,
`ifdef DECODER_NAND_NOR_FULLSET_EN
    output logic [WIDTH-1:0]   and_g,
    output logic [WIDTH-1:0]   or_g,
    output logic [WIDTH-1:0]   xor_g,
    output logic [WIDTH-1:0]   xnor_g,
    output logic [WIDTH-1:0]   and_q,
    output logic [WIDTH-1:0]   or_q,
    output logic [WIDTH-1:0]   xor_q,
    output logic [WIDTH-1:0]   xnor_q,
`endif
    output logic               out_valid
);

    logic [WIDTH-1:0] nand_q_reg;
    logic [WIDTH-1:0] nor_q_reg;
    logic             out_valid_q;

    // Every gate output is an OR of minterms; a/b never feed a gate directly.
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_lane
        dec4_t lane_y;

        dec2to4 u_dec (
            .sel_i ({a[gi], b[gi]}),
            .y_o   (lane_y)
        );

        assign dec_y[4*gi +: 4] = lane_y;
        assign nand_g[gi]       = lane_y[SEL_00] | lane_y[SEL_01] | lane_y[SEL_10];
        assign nor_g[gi]        = lane_y[SEL_00];
`ifdef DECODER_NAND_NOR_FULLSET_EN
        assign and_g[gi]  = lane_y[SEL_11];
        assign or_g[gi]   = lane_y[SEL_01] | lane_y[SEL_10] | lane_y[SEL_11];
        assign xor_g[gi]  = lane_y[SEL_01] | lane_y[SEL_10];
        assign xnor_g[gi] = lane_y[SEL_00] | lane_y[SEL_11];
`endif
    end

`ifdef DECODER_NAND_NOR_FULLSET_EN
    logic [WIDTH-1:0] and_q_reg;
    logic [WIDTH-1:0] or_q_reg;
    logic [WIDTH-1:0] xor_q_reg;
    logic [WIDTH-1:0] xnor_q_reg;
`endif

    // Results load only on qualified edges; out_valid tracks in_valid every edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            nand_q_reg  <= '0;
            nor_q_reg   <= '0;
            out_valid_q <= 1'b0;
`ifdef DECODER_NAND_NOR_FULLSET_EN
            and_q_reg   <= '0;
            or_q_reg    <= '0;
            xor_q_reg   <= '0;
            xnor_q_reg  <= '0;
`endif
        end else begin
            out_valid_q <= in_valid;
            if (in_valid) begin
                nand_q_reg <= nand_g;
                nor_q_reg  <= nor_g;
`ifdef DECODER_NAND_NOR_FULLSET_EN
                and_q_reg  <= and_g;
                or_q_reg   <= or_g;
                xor_q_reg  <= xor_g;
                xnor_q_reg <= xnor_g;
`endif
            end
        end
    end

    assign nand_q    = nand_q_reg;
    assign nor_q     = nor_q_reg;
    assign out_valid = out_valid_q;
`ifdef DECODER_NAND_NOR_FULLSET_EN
    assign and_q  = and_q_reg;
    assign or_q   = or_q_reg;
    assign xor_q  = xor_q_reg;
    assign xnor_q = xnor_q_reg;
`endif

endmodule

// File: tb/tb_decoder_nand_nor.sv
// Directed self-checking bench for decoder_nand_nor (WIDTH=1 and WIDTH=4 instances).
module tb_decoder_nand_nor;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        iv  = 1'b0;
    logic [0:0]  a1  = '0;
    logic [0:0]  b1  = '0;
    logic [3:0]  a4  = '0;
    logic [3:0]  b4  = '0;

    logic [0:0]  nand_g1, nor_g1, nand_q1, nor_q1;
    logic [3:0]  dec_y1;
    logic        ov1;
    logic [3:0]  nand_g4, nor_g4, nand_q4, nor_q4;
    logic [15:0] dec_y4;
    logic        ov4;
`ifdef DECODER_NAND_NOR_FULLSET_EN
    logic [0:0]  and_g1, or_g1, xor_g1, xnor_g1, and_q1, or_q1, xor_q1, xnor_q1;
    logic [3:0]  and_g4, or_g4, xor_g4, xnor_g4, and_q4, or_q4, xor_q4, xnor_q4;
`endif

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    decoder_nand_nor #(.WIDTH(1)) u_dut1 (
        .clk(clk), .rst(rst), .a(a1), .b(b1), .in_valid(iv),
        .nand_g(nand_g1), .nor_g(nor_g1), .dec_y(dec_y1),
        .nand_q(nand_q1), .nor_q(nor_q1),
`ifdef DECODER_NAND_NOR_FULLSET_EN
        .and_g(and_g1), .or_g(or_g1), .xor_g(xor_g1), .xnor_g(xnor_g1),
        .and_q(and_q1), .or_q(or_q1), .xor_q(xor_q1), .xnor_q(xnor_q1),
`endif
        .out_valid(ov1)
    );

    decoder_nand_nor #(.WIDTH(4)) u_dut4 (
        .clk(clk), .rst(rst), .a(a4), .b(b4), .in_valid(iv),
        .nand_g(nand_g4), .nor_g(nor_g4), .dec_y(dec_y4),
        .nand_q(nand_q4), .nor_q(nor_q4),
`ifdef DECODER_NAND_NOR_FULLSET_EN
        .and_g(and_g4), .or_g(or_g4), .xor_g(xor_g4), .xnor_g(xnor_g4),
        .and_q(and_q4), .or_q(or_q4), .xor_q(xor_q4), .xnor_q(xnor_q4),
`endif
        .out_valid(ov4)
    );

    task automatic test_comb();
        logic [1:0] exp_nand [4] = '{1, 1, 1, 0};
        logic [1:0] exp_nor  [4] = '{1, 0, 0, 0};
        logic [3:0] exp_dec  [4] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};
        for (int i = 0; i < 4; i++) begin
            {a1, b1} = 2'(i);
            #10;
            checks++;
            if ({1'b0, nand_g1} !== exp_nand[i][1:0] || {1'b0, nor_g1} !== exp_nor[i][1:0]
                || dec_y1 !== exp_dec[i]) begin
                failures++;
                $display("FAIL comb ab=%0d: nand=%b nor=%b dec=%b required nand=%b nor=%b dec=%b",
                         i, nand_g1, nor_g1, dec_y1, exp_nand[i][0], exp_nor[i][0], exp_dec[i]);
            end else
                $display("comb ab=%0d nand=%b nor=%b dec=%b", i, nand_g1, nor_g1, dec_y1);
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst = 1'b1; iv = 1'b1; a1 = 1'b0; b1 = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++;
        if (nand_q1 !== 1'b0 || nor_q1 !== 1'b0 || ov1 !== 1'b0) begin
            failures++;
            $display("FAIL reset_state: nand_q=%b nor_q=%b ov=%b required 0 0 0", nand_q1, nor_q1, ov1);
        end else
            $display("reset_state nand_q=%b nor_q=%b ov=%b", nand_q1, nor_q1, ov1);
        rst = 1'b0;
        @(posedge clk);
        @(negedge clk);
        checks++;
        if (nand_q1 !== 1'b1 || nor_q1 !== 1'b1 || ov1 !== 1'b1) begin
            failures++;
            $display("FAIL reset_release: nand_q=%b nor_q=%b ov=%b required 1 1 1", nand_q1, nor_q1, ov1);
        end else
            $display("reset_release nand_q=%b nor_q=%b ov=%b", nand_q1, nor_q1, ov1);
    endtask

    task automatic test_hold();
        a1 = 1'b1; b1 = 1'b1; iv = 1'b1;
        @(posedge clk);
        @(negedge clk);
        checks++;
        if (nand_q1 !== 1'b0 || nor_q1 !== 1'b0 || ov1 !== 1'b1) begin
            failures++;
            $display("FAIL hold_capture: nand_q=%b nor_q=%b ov=%b required 0 0 1", nand_q1, nor_q1, ov1);
        end else
            $display("hold_capture nand_q=%b nor_q=%b ov=%b", nand_q1, nor_q1, ov1);
        iv = 1'b0; a1 = 1'b0; b1 = 1'b0;
        #1;
        checks++;
        if (nand_g1 !== 1'b1 || nor_g1 !== 1'b1) begin
            failures++;
            $display("FAIL hold_comb: nand_g=%b nor_g=%b required 1 1", nand_g1, nor_g1);
        end else
            $display("hold_comb nand_g=%b nor_g=%b", nand_g1, nor_g1);
        @(posedge clk);
        @(negedge clk);
        checks++;
        if (nand_q1 !== 1'b0 || nor_q1 !== 1'b0 || ov1 !== 1'b0) begin
            failures++;
            $display("FAIL hold_keep: nand_q=%b nor_q=%b ov=%b required 0 0 0", nand_q1, nor_q1, ov1);
        end else
            $display("hold_keep nand_q=%b nor_q=%b ov=%b", nand_q1, nor_q1, ov1);
    endtask

    task automatic test_wide();
        a4 = 4'b1100; b4 = 4'b1010; iv = 1'b1;
        #1;
        checks++;
        if (nand_g4 !== 4'b0111 || nor_g4 !== 4'b0001 || dec_y4 !== 16'h8421) begin
            failures++;
            $display("FAIL wide_comb: nand=%b nor=%b dec=%h required 0111 0001 8421", nand_g4, nor_g4, dec_y4);
        end else
            $display("wide_comb nand=%b nor=%b dec=%h", nand_g4, nor_g4, dec_y4);
        @(posedge clk);
        @(negedge clk);
        checks++;
        if (nand_q4 !== 4'b0111 || nor_q4 !== 4'b0001 || ov4 !== 1'b1) begin
            failures++;
            $display("FAIL wide_reg: nand_q=%b nor_q=%b ov=%b required 0111 0001 1", nand_q4, nor_q4, ov4);
        end else
            $display("wide_reg nand_q=%b nor_q=%b ov=%b", nand_q4, nor_q4, ov4);
    endtask

    task automatic test_back_to_back();
        logic [1:0] vec      [4] = '{2'b11, 2'b00, 2'b10, 2'b01};
        logic       exp_nand [4] = '{1'b0, 1'b1, 1'b1, 1'b1};
        logic       exp_nor  [4] = '{1'b0, 1'b1, 1'b0, 1'b0};
        iv = 1'b1;
        for (int i = 0; i < 4; i++) begin
            {a1, b1} = vec[i];
            @(posedge clk);
            @(negedge clk);
            checks++;
            if (nand_q1 !== exp_nand[i] || nor_q1 !== exp_nor[i] || ov1 !== 1'b1) begin
                failures++;
                $display("FAIL b2b[%0d]: nand_q=%b nor_q=%b ov=%b required %b %b 1",
                         i, nand_q1, nor_q1, ov1, exp_nand[i], exp_nor[i]);
            end else
                $display("b2b[%0d] ab=%b nand_q=%b nor_q=%b", i, vec[i], nand_q1, nor_q1);
        end
    endtask

    task automatic test_midreset();
        a1 = 1'b0; b1 = 1'b0; a4 = 4'b0000; b4 = 4'b0000; iv = 1'b1;
        @(posedge clk);
        @(negedge clk);
        checks++;
        if (nand_q1 !== 1'b1 || nor_q1 !== 1'b1 || nand_q4 !== 4'hF || nor_q4 !== 4'hF) begin
            failures++;
            $display("FAIL midrst_pre: nand_q1=%b nor_q1=%b nand_q4=%b nor_q4=%b required 1 1 1111 1111",
                     nand_q1, nor_q1, nand_q4, nor_q4);
        end else
            $display("midrst_pre nand_q1=%b nor_q1=%b nand_q4=%b", nand_q1, nor_q1, nand_q4);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        checks++;
        if (nand_q1 !== 1'b0 || nor_q1 !== 1'b0 || ov1 !== 1'b0
            || nand_q4 !== 4'h0 || nor_q4 !== 4'h0 || ov4 !== 1'b0) begin
            failures++;
            $display("FAIL midrst: nand_q1=%b nor_q1=%b ov1=%b nand_q4=%b nor_q4=%b ov4=%b required all 0",
                     nand_q1, nor_q1, ov1, nand_q4, nor_q4, ov4);
        end else
            $display("midrst nand_q1=%b nor_q1=%b ov1=%b", nand_q1, nor_q1, ov1);
        rst = 1'b0;
    endtask

`ifdef DECODER_NAND_NOR_FULLSET_EN
    task automatic test_fullset();
        a1 = 1'b1; b1 = 1'b0; iv = 1'b1;
        #1;
        checks++;
        if (and_g1 !== 1'b0 || or_g1 !== 1'b1 || xor_g1 !== 1'b1 || xnor_g1 !== 1'b0) begin
            failures++;
            $display("FAIL fullset_comb: and=%b or=%b xor=%b xnor=%b required 0 1 1 0",
                     and_g1, or_g1, xor_g1, xnor_g1);
        end else
            $display("fullset_comb and=%b or=%b xor=%b xnor=%b", and_g1, or_g1, xor_g1, xnor_g1);
        @(posedge clk);
        @(negedge clk);
        checks++;
        if (and_q1 !== 1'b0 || or_q1 !== 1'b1 || xor_q1 !== 1'b1 || xnor_q1 !== 1'b0) begin
            failures++;
            $display("FAIL fullset_reg: and_q=%b or_q=%b xor_q=%b xnor_q=%b required 0 1 1 0",
                     and_q1, or_q1, xor_q1, xnor_q1);
        end else
            $display("fullset_reg and_q=%b or_q=%b xor_q=%b xnor_q=%b", and_q1, or_q1, xor_q1, xnor_q1);
    endtask
`endif

    initial begin
        test_comb();
        test_reset();
        test_hold();
        test_wide();
        test_back_to_back();
        test_midreset();
`ifdef DECODER_NAND_NOR_FULLSET_EN
        test_fullset();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
